alu_b_operand_stage: RTL and testbench
======================================

# alu_b_operand_stage

Parametrised, pipelined operand-B stage for the ALU. It selects one of `NUM_SRC` source buses or a constant, applies an operand transform (NOT, negate, shift-by-2, 16-bit extension, zero), and registers the result behind a valid/ready handshake with a 2-entry skid buffer. It sits between the register-file/immediate datapath and the ALU B port, so control can stall the ALU without losing operands.

## Interface
- `WIDTH`, 32: operand width in bits; must be ≥ 16.
- `NUM_SRC`, 4: number of source buses; must be ≥ 2.
- `CONST_VAL`, 4: constant driven by op CONST, truncated to `WIDTH`.
- `SEL_W`, `$clog2(NUM_SRC)`: derived; not overridden.

- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `flush`  in  1  synchronous discard of all buffered operands
- `in_valid`  in  1  source/op fields valid
- `in_ready`  out  1  stage can accept this cycle
- `src_sel`  in  `SEL_W`  source index; values ≥ `NUM_SRC` select source 0
- `op`  in  3  transform code (see Operation)
- `data_in`  in  `NUM_SRC*WIDTH`  flattened sources; source k is bits [k*WIDTH +: WIDTH]
- `out_valid`  out  1  `out_data` holds an operand
- `out_ready`  in  1  ALU consumes this cycle
- `out_data`  out  `WIDTH`  transformed operand
- `out_count`  out  2  entries held, 0..2

## Operation
- Source value `s = data_in[src_sel]`.
- Op codes:
  - 0 PASS → `s`
  - 1 CONST → `CONST_VAL`
  - 2 NOT → `~s`
  - 3 NEG → `~s + 1`, modulo 2^WIDTH
  - 4 SHL2 → `s << 2`, upper bits dropped
  - 5 SEXT16 → `s[15:0]` sign-extended to `WIDTH`
  - 6 ZEXT16 → `s[15:0]` zero-extended
  - 7 ZERO → 0
- Transform is combinational on the input side. Only the result is stored, never `src_sel`, `op` or `data_in`.
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Storage: main register (drives `out_data`) plus skid register.
- State by `out_count`:
  - EMPTY (0): input transfer loads main → ONE.
  - ONE (1):
    - input only → skid loaded → FULL.
    - output only → EMPTY.
    - input and output together → main reloaded with new result, stays ONE.
  - FULL (2): output transfer moves skid → main → ONE. No input is accepted.
- `in_ready = (out_count != 2)`. It is a function of registered state only, with no combinational path from `out_ready`.
- `out_valid = (out_count != 0)`.
- Ordering is strictly FIFO. No operand is dropped or duplicated except by `flush` or `reset`.
- `flush`: next state EMPTY. An input transfer in the same cycle is discarded. `out_data` keeps its last value, and `out_valid` is 0 the next cycle.
- Priority: `reset` > `flush` > normal operation.

## Timing
- Latency 1 cycle: an operand accepted at edge N appears at `out_data` with `out_valid=1` after edge N, when entering EMPTY or in the ONE in+out case.
- Throughput 1 operand/cycle when `out_ready` is held high.
- With `out_ready` low, 2 operands are absorbed, then `in_ready` falls in the cycle after the second acceptance.
- While `reset` is high, inputs are ignored.
- Reset values: `out_valid=0`, `out_data=0`, `out_count=0`, skid register 0. `in_ready` reads 1 while `reset` is high and thereafter.
- `reset` asserted mid-operation discards both entries at that edge.
- `out_data` is stable while `out_valid && !out_ready`.

## Structure
- Package `alu_b_pkg`:
  - op enum `alu_b_op_t` (3 bits; codes PASS..ZERO as above)
  - `ALU_B_OP_W = 3`
  - `EXT_W = 16`
- Sub-module `alu_b_skid_buffer #(WIDTH)`: generic 2-entry valid/ready skid buffer with `flush` and `count`.
- The top level holds the source mux and transform function, and instantiates one skid buffer.

## Test plan
- Reset check: assert `reset` 2 cycles with `in_valid=1` → `out_valid=0`, `out_data=0`, `out_count=0`, `in_ready=1`, and no operand appears after release.
- All ops, `WIDTH=32`, `src_sel=2`, `data_in` source 2 = `0x0000_8001`, `out_ready=1`, ops 0..7 back-to-back → `0x00008001`, `0x4`, `0xFFFF7FFE`, `0xFFFF7FFF`, `0x00020004`, `0xFFFF8001`, `0x00008001`, `0x0`, one per cycle, each 1 cycle after issue.
- Backpressure: `out_ready=0`, push A=1, B=2, C=3 (PASS) → A and B accepted, `in_ready=0` with `out_count=2`, C held. Then raise `out_ready` → A, B, C emerge in order with no gaps once draining.
- Simultaneous events: in ONE, do input and output transfer in the same cycle → `out_count` stays 1 and `out_data` becomes the new operand next cycle.
- Flush while FULL, with `in_valid=1` the same cycle → next cycle `out_valid=0`, `out_count=0`, and the flushed and concurrent operands never appear.
- Parameter sweep: `NUM_SRC=3`, `WIDTH=16`, `src_sel=3` → source 0 selected. NEG of `0x8000` → `0x8000`. SHL2 of `0xC001` → `0x0004`.

Source files
------------

// File: rtl/alu_b_pkg.sv
// Shared types and widths for the ALU operand-B stage.
package alu_b_pkg;

    localparam int unsigned ALU_B_OP_W = 3;
    localparam int unsigned EXT_W      = 16;

    typedef enum logic [ALU_B_OP_W-1:0] {
        OP_PASS   = 3'd0,
        OP_CONST  = 3'd1,
        OP_NOT    = 3'd2,
        OP_NEG    = 3'd3,
        OP_SHL2   = 3'd4,
        OP_SEXT16 = 3'd5,
        OP_ZEXT16 = 3'd6,
        OP_ZERO   = 3'd7
    } alu_b_op_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/alu_b_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with flush; main register drives out_data.
module alu_b_skid_buffer
    import alu_b_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    skid_state_t      state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             in_xfer, out_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= SKID_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // Next-state: flush empties the buffer but leaves main_q untouched.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        in_xfer   = in_valid && (state != SKID_FULL);
        out_xfer  = out_ready && (state != SKID_EMPTY);
        if (flush) begin
            state_nxt = SKID_EMPTY;
        end else begin
            unique case (state)
                SKID_EMPTY: begin
                    if (in_xfer) begin
                        main_nxt  = in_data;
                        state_nxt = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_nxt = in_data;
                    end else if (in_xfer) begin
                        skid_nxt  = in_data;
                        state_nxt = SKID_FULL;
                    end else if (out_xfer) begin
                        state_nxt = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (out_xfer) begin
                        main_nxt  = skid_q;
                        state_nxt = SKID_ONE;
                    end
                end
                default: state_nxt = SKID_EMPTY;
            endcase
        end
    end

    assign in_ready  = reset || (state != SKID_FULL);
    assign out_valid = (state != SKID_EMPTY);
    assign out_data  = main_q;
    assign count     = 2'(state);

endmodule

// File: rtl/alu_b_operand_stage.sv
// Operand-B stage: source mux + transform, buffered behind a 2-entry skid buffer.
module alu_b_operand_stage
    import alu_b_pkg::*;
#(
    parameter  int unsigned WIDTH     = 32,
    parameter  int unsigned NUM_SRC   = 4,
    parameter  int unsigned CONST_VAL = 4,
    localparam int unsigned SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [ALU_B_OP_W-1:0]    op,
    input  logic [NUM_SRC*WIDTH-1:0] data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [1:0]               out_count
);

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] result;

    function automatic logic [WIDTH-1:0] transform(input alu_b_op_t code, input logic [WIDTH-1:0] s);
        unique case (code)
            OP_PASS:   transform = s;
            OP_CONST:  transform = WIDTH'(CONST_VAL);
            OP_NOT:    transform = ~s;
            OP_NEG:    transform = ~s + WIDTH'(1);
            OP_SHL2:   transform = s << 2;
            OP_SEXT16: transform = WIDTH'($signed(s[EXT_W-1:0]));
            OP_ZEXT16: transform = WIDTH'(s[EXT_W-1:0]);
            OP_ZERO:   transform = '0;
            default:   transform = '0;
        endcase
    endfunction

    // Out-of-range selects fall back to source 0.
    always_comb begin
        src = data_in[WIDTH-1:0];
        for (int unsigned k = 1; k < NUM_SRC; k++) begin
            if (src_sel == SEL_W'(k)) src = data_in[k*WIDTH +: WIDTH];
        end
    end

    assign result = transform(alu_b_op_t'(op), src);

    alu_b_skid_buffer #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (out_count)
    );

endmodule

// File: tb/tb_alu_b_operand_stage.sv
// Self-checking bench for alu_b_operand_stage: directed cases plus random traffic vs a queue model.
module tb_alu_b_operand_stage;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   src_sel = '0;
    logic [2:0]   op = '0;
    logic [127:0] din = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic [1:0]   out_count;

    logic         s_in_valid = 1'b0;
    logic         s_in_ready;
    logic [1:0]   s_src_sel = '0;
    logic [2:0]   s_op = '0;
    logic [47:0]  s_din = '0;
    logic         s_out_valid;
    logic [15:0]  s_out_data;
    logic [1:0]   s_out_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] q[$];
    logic [31:0] hold = '0;

    always #5 clk = ~clk;

    alu_b_operand_stage u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .src_sel(src_sel), .op(op), .data_in(din), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count)
    );

    alu_b_operand_stage #(.WIDTH(16), .NUM_SRC(3)) u_dut16 (
        .clk(clk), .reset(reset), .flush(1'b0), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .src_sel(s_src_sel), .op(s_op), .data_in(s_din), .out_valid(s_out_valid), .out_ready(1'b1),
        .out_data(s_out_data), .out_count(s_out_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input int code, input logic [31:0] s);
        longint unsigned v;
        case (code)
            0: return s;
            1: return 32'd4;
            2: return 32'hFFFF_FFFF - s;
            3: return 32'(64'h1_0000_0000 - longint'(s));
            4: return 32'(longint'(s) * 4);
            5: begin
                v = longint'(s) % 65536;
                if (v >= 32768) v = v + 64'hFFFF_0000;
                return 32'(v);
            end
            6: return 32'(longint'(s) % 65536);
            default: return 32'd0;
        endcase
    endfunction

    // Advance the queue model for the inputs now applied, clock once, then compare.
    task automatic cycle();
        logic acc, deq;
        logic [31:0] s;
        s   = din[src_sel*32 +: 32];
        acc = in_valid && (q.size() < 2);
        deq = out_ready && (q.size() > 0);
        if (reset) begin
            q.delete();
            hold = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(ref_op(int'(op), s));
        end
        if (q.size() > 0) hold = q[0];
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("out_count", 64'(out_count), 64'(q.size()));
        check("in_ready", 64'(in_ready), 64'(q.size() != 2));
        check("out_data", 64'(out_data), 64'(hold));
    endtask

    task automatic set_src(input int k, input logic [31:0] v);
        din[k*32 +: 32] = v;
    endtask

    initial begin
        logic [31:0] exp_ops [8];
        exp_ops = '{32'h0000_8001, 32'h4, 32'hFFFF_7FFE, 32'hFFFF_7FFF,
                    32'h0002_0004, 32'hFFFF_8001, 32'h0000_8001, 32'h0};

        // Reset held two cycles with in_valid high.
        in_valid = 1'b1;
        set_src(0, 32'hDEAD_BEEF);
        cycle();
        cycle();
        check("rst_in_ready_during", 64'(in_ready), 64'd1);
        reset = 1'b0;
        in_valid = 1'b0;
        cycle();
        cycle();
        check("rst_no_operand", 64'(out_valid), 64'd0);

        // All ops back-to-back on source 2.
        out_ready = 1'b1;
        src_sel = 2'd2;
        set_src(2, 32'h0000_8001);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            cycle();
            check($sformatf("op%0d", i), 64'(out_data), 64'(exp_ops[i]));
        end
        in_valid = 1'b0;
        cycle();

        // Backpressure: A, B absorbed, C held until drain.
        out_ready = 1'b0;
        op = 3'd0;
        src_sel = 2'd0;
        in_valid = 1'b1;
        set_src(0, 32'd1);
        cycle();
        set_src(0, 32'd2);
        cycle();
        check("bp_full", 64'(out_count), 64'd2);
        set_src(0, 32'd3);
        cycle();
        check("bp_held_a", 64'(out_data), 64'd1);
        out_ready = 1'b1;
        cycle();
        check("bp_b", 64'(out_data), 64'd2);
        cycle();
        check("bp_c", 64'(out_data), 64'd3);
        in_valid = 1'b0;
        cycle();

        // Simultaneous in+out while ONE.
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_src(0, 32'h1111);
        cycle();
        out_ready = 1'b1;
        set_src(0, 32'h2222);
        cycle();
        check("sim_count", 64'(out_count), 64'd1);
        check("sim_data", 64'(out_data), 64'h2222);

        // Flush while FULL with a concurrent input.
        out_ready = 1'b0;
        set_src(0, 32'h3333);
        cycle();
        check("fl_full", 64'(out_count), 64'd2);
        flush = 1'b1;
        set_src(0, 32'h4444);
        cycle();
        check("fl_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();

        // Narrow/odd-source instance.
        s_in_valid = 1'b1;
        s_src_sel = 2'd3;
        s_op = 3'd0;
        s_din = {16'hAAAA, 16'hBBBB, 16'h1234};
        @(posedge clk); #1;
        check("w16_sel3", 64'(s_out_data), 64'h1234);
        s_op = 3'd3;
        s_din[15:0] = 16'h8000;
        @(posedge clk); #1;
        check("w16_neg", 64'(s_out_data), 64'h8000);
        s_op = 3'd4;
        s_din[15:0] = 16'hC001;
        @(posedge clk); #1;
        check("w16_shl2", 64'(s_out_data), 64'h0004);
        s_op = 3'd5;
        s_din[15:0] = 16'h8001;
        @(posedge clk); #1;
        check("w16_sext", 64'(s_out_data), 64'h8001);
        s_in_valid = 1'b0;
        cycle();

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            din       = {$urandom, $urandom, $urandom, $urandom};
            src_sel   = 2'($urandom_range(0, 3));
            op        = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
